// File: rtl/ks_dec.sv
// ks_dec -- DES decryption key schedule.
//
// Emits the 16 DES round keys in reverse order (K16 first, K1 last) over a
// valid/ready handshake. PC-1 of the key equals C16D16 because the forward
// schedule rotates each half by 28 in total. Each later key is produced by
// rotating C and D right by the forward shift amount of the round just sent.
// Bit numbering follows FIPS 46-3, so bit 1 is the MSB of every vector.
//
// Parameters
//   PARITY_CHECK  1: flag keyIn bytes with even parity at start; 0: parity_err = 0
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   start       in   load keyIn and begin a schedule (IDLE only)
//   keyIn       in   64-bit DES key including parity bits
//   key_ready   in   consumer accepts roundKey this cycle
//   roundKey    out  PC-2 of the current C/D register
//   key_valid   out  roundKey/roundNum valid
//   roundNum    out  DES round index of roundKey, 16 down to 1 (0 when idle)
//   busy        out  high while a schedule runs
//   done        out  one-cycle pulse after K1 is accepted
//   parity_err  out  sticky per schedule; set if any keyIn byte has even parity

module ks_dec #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] keyIn,
    input  logic        key_ready,
    output logic [47:0] roundKey,
    output logic        key_valid,
    output logic [4:0]  roundNum,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Tables list FIPS bit numbers (1 = MSB), output bit 1 first.
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int unsigned j = 0; j < 56; j++) begin
            src    = 6'(64 - PC1[j]);
            dst    = 6'(55 - j);
            r[dst] = k[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd_in);
        logic [47:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int unsigned j = 0; j < 48; j++) begin
            src    = 6'(56 - PC2[j]);
            dst    = 6'(47 - j);
            r[dst] = cd_in[src];
        end
        return r;
    endfunction

    // Right rotation toward bit 28 (C) / bit 56 (D): undoes a forward left shift.
    function automatic logic [55:0] rot_right(input logic [55:0] cd_in, input logic by_two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd_in[55:28];
        d = cd_in[27:0];
        if (by_two) begin
            c = {c[1:0], c[27:2]};
            d = {d[1:0], d[27:2]};
        end else begin
            c = {c[0], c[27:1]};
            d = {d[0], d[27:1]};
        end
        return {c, d};
    endfunction

    state_t      state, state_nxt;
    logic [55:0] cd, cd_nxt;
    logic [4:0]  round_num, round_num_nxt;
    logic        done_r, done_nxt;
    logic        perr_r, perr_nxt;
    logic        key_parity_bad;
    logic        single_shift;

    // Odd parity is required per byte; an even byte count of ones is an error.
    always_comb begin
        logic [63:0] k;
        k              = keyIn;
        key_parity_bad = 1'b0;
        for (int unsigned b = 0; b < 8; b++) begin
            key_parity_bad = key_parity_bad | ~(^k[7:0]);
            k              = k >> 8;
        end
        if (!PARITY_CHECK) begin
            key_parity_bad = 1'b0;
        end
    end

    // Forward shift of the round whose key is being sent: 1 for rounds 16, 9, 2.
    always_comb begin
        single_shift = (round_num == 5'd16) || (round_num == 5'd9) || (round_num == 5'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cd        <= '0;
            round_num <= '0;
            done_r    <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cd        <= cd_nxt;
            round_num <= round_num_nxt;
            done_r    <= done_nxt;
            perr_r    <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cd_nxt        = cd;
        round_num_nxt = round_num;
        done_nxt      = 1'b0;
        perr_nxt      = perr_r;

        key_valid  = (state == RUN);
        busy       = (state == RUN);
        roundKey   = pc2(cd);
        roundNum   = round_num;
        done       = done_r;
        parity_err = perr_r;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    cd_nxt        = pc1(keyIn);
                    round_num_nxt = 5'd16;
                    perr_nxt      = key_parity_bad;
                end
            end
            RUN: begin
                if (key_ready) begin
                    if (round_num == 5'd1) begin
                        state_nxt     = IDLE;
                        round_num_nxt = '0;
                        done_nxt      = 1'b1;
                    end else begin
                        cd_nxt        = rot_right(cd, ~single_shift);
                        round_num_nxt = round_num - 5'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
